// File: rtl/mem_access_stage.sv
// Pipeline MEM stage: issues load/store accesses on a req/ack data-memory port,
// stalls the front of the pipeline while memory is busy and owns the MEM/WB register.
// Misaligned word accesses and memory timeouts become bubbles with one-cycle error pulses.
module mem_access_stage #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] EXE_MEM_Result,
  input  logic [31:0] EXE_MEM_Rt,
  input  logic [4:0]  EXE_MEM_DstReg,
  input  logic        EXE_MEM_MemRead,
  input  logic        EXE_MEM_MemWrite,
  input  logic        EXE_MEM_MemtoReg,
  input  logic        EXE_MEM_RegWrite,
  input  logic        EXE_MEM_Byte,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        MEM_Stall,
  output logic        MEM_AlignErr,
  output logic        MEM_BusErr,
  output logic [31:0] MEM_WB_Result,
  output logic [31:0] MEM_WB_ReadData,
  output logic [4:0]  MEM_WB_DstReg,
  output logic        MEM_WB_MemtoReg,
  output logic        MEM_WB_RegWrite
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  typedef enum logic {StIdle, StWait} state_e;

  state_e          state_q;
  logic [CntW-1:0] cnt_q;

  logic        access;
  logic        is_load;
  logic        aligned;
  logic        at_limit;
  logic        complete;
  logic        abort;
  logic        wb_valid;
  logic [1:0]  lane_sel;
  logic [7:0]  lane_byte;
  logic [31:0] load_data;

  assign access   = EXE_MEM_MemRead | EXE_MEM_MemWrite;
  // Read and write together is treated as a store.
  assign is_load  = EXE_MEM_MemRead & ~EXE_MEM_MemWrite;
  assign aligned  = EXE_MEM_Byte | (EXE_MEM_Result[1:0] == 2'b00);
  assign lane_sel = EXE_MEM_Result[1:0];
  assign at_limit = (cnt_q == CntW'(TIMEOUT));

  // Request fields come straight from EXE/MEM; upstream holds them stable while stalled.
  always_comb begin
    dmem_addr  = {EXE_MEM_Result[31:2], 2'b00};
    dmem_we    = EXE_MEM_MemWrite;
    dmem_wdata = EXE_MEM_Byte ? {4{EXE_MEM_Rt[7:0]}} : EXE_MEM_Rt;
    dmem_be    = EXE_MEM_Byte ? (4'b1000 >> lane_sel) : 4'b1111;
  end

  // Big-endian lane pick and sign extension for byte loads.
  always_comb begin
    lane_byte = 8'h00;
    unique case (lane_sel)
      2'd0: lane_byte = dmem_rdata[31:24];
      2'd1: lane_byte = dmem_rdata[23:16];
      2'd2: lane_byte = dmem_rdata[15:8];
      2'd3: lane_byte = dmem_rdata[7:0];
    endcase
    load_data = EXE_MEM_Byte ? {{24{lane_byte[7]}}, lane_byte} : dmem_rdata;
  end

  // Handshake, abort and stall decisions for the current cycle.
  always_comb begin
    dmem_req  = rst_n & ((state_q == StWait) | (access & aligned));
    complete  = dmem_req & dmem_ack;
    abort     = rst_n & (state_q == StWait) & ~dmem_ack & at_limit;
    MEM_Stall = dmem_req & ~dmem_ack & ~abort;
    // Non-memory instructions pass straight through; accesses only on completion.
    wb_valid  = ((state_q == StIdle) & ~access) | complete;
  end

  // FSM, wait counter and error pulses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      MEM_AlignErr <= 1'b0;
      MEM_BusErr   <= 1'b0;
    end else begin
      MEM_AlignErr <= (state_q == StIdle) & access & ~aligned;
      MEM_BusErr   <= abort;
      unique case (state_q)
        StIdle: begin
          if (dmem_req && !dmem_ack) begin
            state_q <= StWait;
            cnt_q   <= CntW'(1);
          end
        end
        StWait: begin
          if (dmem_ack || at_limit) begin
            state_q <= StIdle;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        default: begin
          state_q <= StIdle;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  // MEM/WB register: loads every cycle, bubble when stalled, aborted or misaligned.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      MEM_WB_Result   <= '0;
      MEM_WB_ReadData <= '0;
      MEM_WB_DstReg   <= '0;
      MEM_WB_MemtoReg <= 1'b0;
      MEM_WB_RegWrite <= 1'b0;
    end else if (wb_valid) begin
      MEM_WB_Result   <= EXE_MEM_Result;
      MEM_WB_DstReg   <= EXE_MEM_DstReg;
      MEM_WB_MemtoReg <= EXE_MEM_MemtoReg & ~EXE_MEM_MemWrite;
      MEM_WB_RegWrite <= EXE_MEM_RegWrite;
      if (complete && is_load) begin
        MEM_WB_ReadData <= load_data;
      end
    end else begin
      MEM_WB_DstReg   <= '0;
      MEM_WB_MemtoReg <= 1'b0;
      MEM_WB_RegWrite <= 1'b0;
    end
  end

endmodule
